spi_ram_responder: RTL and testbench
====================================

# spi_ram_responder

Synthesizable single-bit SPI SRAM device model: the responder end of the SPI memory link that the SPI memory controller drives as initiator. It decodes READ/WRITE/RDMR/WRMR transactions in SPI mode 0, MSB first, and maps them onto a byte-wide synchronous memory port. It sits on the user IO pads opposite the controller's RAM pins (csb/clk/io0/io1), so the RAM path can be exercised on FPGA and in gate-level simulation without the behavioural SPI_RAM model. The SPI pins are oversampled on the system clock.

## Interface
- ADDRESS_BITS, 17, memory address width; the wire address is always 24 bits and only the low ADDRESS_BITS are used.
- PAGE_BYTES, 32, page size for page mode; must be a power of two.
- clk  in  1  system clock; must be at least 8x the sck frequency.
- rst  in  1  reset, asynchronous, active-low.
- sck  in  1  SPI clock, asynchronous to clk.
- csb  in  1  SPI chip select, active-low, asynchronous.
- mosi  in  1  io0, sampled on sck rising edge.
- miso  out  1  io1, updated on sck falling edge; 0 when not driving.
- misoEnable  out  1  1 while a READ or RDMR data phase is active.
- memAddress  out  ADDRESS_BITS  byte address.
- memWriteEnable  out  1  single-cycle write strobe.
- memDataWrite  out  8  write data.
- memReadEnable  out  1  single-cycle read strobe; data is valid on memDataRead on the next clk.
- memDataRead  in  8  read data.
- mode  out  2  current mode register bits [7:6].

## Operation
- Synchronisers: sck, csb and mosi each pass through 2 flops. Edge detect uses the synchronised sck. A synchronised csb high forces state IDLE in the same cycle.
- Commands: 0x03 READ, 0x02 WRITE, 0x05 RDMR, 0x01 WRMR. Any other opcode goes to IGNORE until csb rises.
- States:
  - IDLE: csb low goes to COMMAND.
  - COMMAND: 8 bits. Then READ/WRITE go to ADDRESS, 0x05 goes to READ_STATUS, 0x01 goes to WRITE_STATUS.
  - ADDRESS: 24 bits. Then READ_DATA or WRITE_DATA.
  - READ_DATA, WRITE_DATA, READ_STATUS: remain in these states until csb rises.
  - WRITE_STATUS: one byte, then IGNORE.
- Mode register:
  - bits [7:6]: 00 = byte, 10 = page, 01 = sequential, 11 = reserved and treated as sequential. Reset value 01. Other bits read as 0.
  - RDMR returns the register repeatedly until csb rises.
- Address advance after each data byte:
  - byte mode: the address does not advance; repeated bytes access the same location.
  - page mode: the low log2(PAGE_BYTES) bits increment and wrap, and the upper bits are held.
  - sequential mode: increments modulo 2^ADDRESS_BITS.
- WRITE:
  - Each completed byte drives memWriteEnable for one clk, on the cycle after the 8th bit is sampled, with the current address.
  - If csb rises mid-byte, the partial byte is discarded and no write occurs.
- READ:
  - memReadEnable is asserted on the clk after the last address bit is sampled. The returned byte loads the output shift register.
  - Bit 7 is driven on the next sck falling edge.
  - When bit 0 of the current byte is driven, the next address is read so the following byte is ready before its first falling edge.
- Reset clears all state. Outputs take these values: miso 0, misoEnable 0, memWriteEnable 0, memReadEnable 0, memAddress 0, memDataWrite 0, mode 01.

## Timing
- Input latency: a pin change is seen 2 clk later; the edge is detected on the 3rd clk.
- The memory strobe occurs 1 clk after the detected rising edge of the 8th data bit, or of the 24th address bit.
- miso updates within 3 clk of the sck falling pin edge; at 8x oversampling this leaves 1 clk of margin before the next rising edge.
- misoEnable rises with the first data-phase falling edge and falls within 3 clk of csb rising.
- Simultaneous events:
  - csb rising in the same clk as the 8th bit of a write completes: the write is suppressed, because csb wins.
  - A read prefetch already issued is harmless when csb rises before the data is used.
- sck edges while csb is high are ignored.

## Structure
- Shared package spi_memory_pkg holds:
  - opcode constants, so the controller and responder use one definition;
  - mode encodings MODE_BYTE, MODE_PAGE, MODE_SEQUENTIAL;
  - the state enum.
- Sub-module spi_pin_synchroniser: 2-flop synchroniser plus rise/fall detect, instantiated for sck and csb, with the mosi synchroniser path only.
- Memory port kept generic so an sky130 SRAM macro or a behavioural array can be attached.

## Test plan
- WRITE 0x02, address 0x000100, bytes 0xA5 0x5A, then READ 0x03 at 0x000100 -> memWriteEnable pulses twice at addresses 0x100/0x101; the read returns 0xA5 0x5A on miso.
- WRMR 0x01 with 0x00 (byte mode), then WRITE at 0x40 with 0x11 0x22 -> both writes go to address 0x40; RDMR 0x05 returns 0x00 repeatedly.
- Page mode (WRMR 0x80), READ at 0x1F for 2 bytes -> memAddress sequence 0x1F, 0x00.
- Sequential read at 0x1FFFF for 2 bytes -> the addresses wrap to 0x00000.
- csb raised after 5 data bits of a write -> no memWriteEnable, state returns to IDLE, and the next transaction is decoded normally.
- Opcode 0x9F followed by 32 sck cycles -> no memory strobes, misoEnable stays 0; rst asserted mid-READ -> all outputs reach reset values immediately and mode is 01.

Source files
------------

// File: rtl/spi_memory_pkg.sv
// rtl/spi_memory_pkg.sv - shared SPI memory opcodes, mode encodings and responder state enum
// Used by both the SPI memory controller and the SPI RAM responder so the two
// ends of the link agree on one definition of the wire protocol.
package spi_memory_pkg;

    localparam logic [7:0] OPCODE_READ  = 8'h03;
    localparam logic [7:0] OPCODE_WRITE = 8'h02;
    localparam logic [7:0] OPCODE_RDMR  = 8'h05;
    localparam logic [7:0] OPCODE_WRMR  = 8'h01;

    // Mode register bits [7:6]; 2'b11 is reserved and behaves as sequential.
    localparam logic [1:0] MODE_BYTE       = 2'b00;
    localparam logic [1:0] MODE_PAGE       = 2'b10;
    localparam logic [1:0] MODE_SEQUENTIAL = 2'b01;

    typedef enum logic [2:0] {
        STATE_IDLE,
        STATE_COMMAND,
        STATE_ADDRESS,
        STATE_READ_DATA,
        STATE_WRITE_DATA,
        STATE_READ_STATUS,
        STATE_WRITE_STATUS,
        STATE_IGNORE
    } spi_state_t;

endpackage

// File: rtl/spi_pin_synchroniser.sv
// rtl/spi_pin_synchroniser.sv - two-flop pin synchroniser with rise/fall detect
// Ports:
//   clk, rst  system clock, asynchronous active-low reset
//   pin       asynchronous input pin
//   level     synchronised pin level (2 clk behind the pin)
//   rise      one-cycle pulse on a synchronised 0->1 transition
//   fall      one-cycle pulse on a synchronised 1->0 transition
module spi_pin_synchroniser #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic stage1;
    logic stage2;
    logic previous;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage1   <= RESET_VALUE;
            stage2   <= RESET_VALUE;
            previous <= RESET_VALUE;
        end else begin
            stage1   <= pin;
            stage2   <= stage1;
            previous <= stage2;
        end
    end

    assign level = stage2;
    assign rise  = stage2 & ~previous;
    assign fall  = ~stage2 & previous;

endmodule

// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - oversampled SPI mode-0 SRAM responder on a byte-wide memory port
// Ports:
//   clk, rst        system clock (>= 8x sck), asynchronous active-low reset
//   sck, csb, mosi  SPI pins, asynchronous to clk
//   miso            serial data out, updated after sck falling edges; 0 when idle
//   misoEnable      high while a READ or RDMR data phase is driving miso
//   memAddress      byte address to the memory
//   memWriteEnable  single-cycle write strobe, with memDataWrite
//   memReadEnable   single-cycle read strobe; memDataRead is valid the next clk
//   mode            mode register bits [7:6]
module spi_ram_responder
    import spi_memory_pkg::*;
#(
    parameter int ADDRESS_BITS = 17,
    parameter int PAGE_BYTES   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sck,
    input  logic                    csb,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    misoEnable,
    output logic [ADDRESS_BITS-1:0] memAddress,
    output logic                    memWriteEnable,
    output logic [7:0]              memDataWrite,
    output logic                    memReadEnable,
    input  logic [7:0]              memDataRead,
    output logic [1:0]              mode
);

    // The shifter only keeps the bits we can use: upper wire-address bits
    // simply fall off the top, which leaves the low ADDRESS_BITS behind.
    localparam int SW = (ADDRESS_BITS > 8) ? ADDRESS_BITS : 8;
    localparam logic [ADDRESS_BITS-1:0] PAGE_MASK = ADDRESS_BITS'(PAGE_BYTES - 1);

    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic csb_level;
    logic csb_rise_unused;
    logic csb_fall_unused;
    logic mosi_meta;
    logic mosi_sync;

    spi_pin_synchroniser #(.RESET_VALUE(1'b0)) sck_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_pin_synchroniser #(.RESET_VALUE(1'b1)) csb_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (csb),
        .level (csb_level),
        .rise  (csb_rise_unused),
        .fall  (csb_fall_unused)
    );

    // mosi shares the sck synchroniser depth so it is aligned with sck_rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    function automatic logic [ADDRESS_BITS-1:0] next_address(
        input logic [ADDRESS_BITS-1:0] current,
        input logic [1:0]              mode_bits
    );
        logic [ADDRESS_BITS-1:0] incremented;
        incremented = current + 1'b1;
        case (mode_bits)
            MODE_BYTE: next_address = current;
            MODE_PAGE: next_address = (current & ~PAGE_MASK) | (incremented & PAGE_MASK);
            default:   next_address = incremented;
        endcase
    endfunction

    spi_state_t      state;
    logic [4:0]      bit_count;
    logic [SW-2:0]   shift_in;
    logic [SW-1:0]   shifted;
    logic            read_command;
    logic            read_capture;
    logic [2:0]      out_count;
    logic [7:0]      out_shift;
    logic [7:0]      byte_now;

    assign shifted = {shift_in, mosi_sync};

    // RDMR reloads the mode byte at the start of every output byte.
    always_comb begin
        byte_now = out_shift;
        if (state == STATE_READ_STATUS && out_count == 3'd0) begin
            byte_now = {mode, 6'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= STATE_IDLE;
            bit_count      <= 5'd0;
            shift_in       <= '0;
            read_command   <= 1'b0;
            read_capture   <= 1'b0;
            out_count      <= 3'd0;
            out_shift      <= 8'h00;
            miso           <= 1'b0;
            misoEnable     <= 1'b0;
            memAddress     <= '0;
            memWriteEnable <= 1'b0;
            memDataWrite   <= 8'h00;
            memReadEnable  <= 1'b0;
            mode           <= MODE_SEQUENTIAL;
        end else begin
            memWriteEnable <= 1'b0;
            memReadEnable  <= 1'b0;
            read_capture   <= memReadEnable;
            if (read_capture) begin
                out_shift <= memDataRead;
            end
            // Advance one clk after the write strobe so the strobe sees the current address.
            if (memWriteEnable) begin
                memAddress <= next_address(memAddress, mode);
            end

            if (csb_level) begin
                // csb high wins over any bit completing in this cycle.
                state      <= STATE_IDLE;
                bit_count  <= 5'd0;
                out_count  <= 3'd0;
                miso       <= 1'b0;
                misoEnable <= 1'b0;
            end else begin
                case (state)
                    STATE_IDLE: begin
                        state     <= STATE_COMMAND;
                        bit_count <= 5'd0;
                    end
                    STATE_COMMAND: begin
                        if (sck_rise) begin
                            shift_in  <= shifted[SW-2:0];
                            bit_count <= bit_count + 5'd1;
                            if (bit_count == 5'd7) begin
                                bit_count <= 5'd0;
                                case (shifted[7:0])
                                    OPCODE_READ: begin
                                        read_command <= 1'b1;
                                        state        <= STATE_ADDRESS;
                                    end
                                    OPCODE_WRITE: begin
                                        read_command <= 1'b0;
                                        state        <= STATE_ADDRESS;
                                    end
                                    OPCODE_RDMR: state <= STATE_READ_STATUS;
                                    OPCODE_WRMR: state <= STATE_WRITE_STATUS;
                                    default:     state <= STATE_IGNORE;
                                endcase
                            end
                        end
                    end
                    STATE_ADDRESS: begin
                        if (sck_rise) begin
                            shift_in  <= shifted[SW-2:0];
                            bit_count <= bit_count + 5'd1;
                            if (bit_count == 5'd23) begin
                                bit_count     <= 5'd0;
                                memAddress    <= shifted[ADDRESS_BITS-1:0];
                                memReadEnable <= read_command;
                                state         <= read_command ? STATE_READ_DATA : STATE_WRITE_DATA;
                            end
                        end
                    end
                    STATE_WRITE_DATA: begin
                        if (sck_rise) begin
                            shift_in  <= shifted[SW-2:0];
                            bit_count <= bit_count + 5'd1;
                            if (bit_count == 5'd7) begin
                                bit_count      <= 5'd0;
                                memWriteEnable <= 1'b1;
                                memDataWrite   <= shifted[7:0];
                            end
                        end
                    end
                    STATE_WRITE_STATUS: begin
                        if (sck_rise) begin
                            shift_in  <= shifted[SW-2:0];
                            bit_count <= bit_count + 5'd1;
                            if (bit_count == 5'd7) begin
                                bit_count <= 5'd0;
                                mode      <= shifted[7:6];
                                state     <= STATE_IGNORE;
                            end
                        end
                    end
                    STATE_READ_DATA, STATE_READ_STATUS: begin
                        if (sck_fall) begin
                            miso       <= byte_now[7];
                            out_shift  <= {byte_now[6:0], 1'b0};
                            misoEnable <= 1'b1;
                            out_count  <= out_count + 3'd1;
                            // Bit 0 is going out: fetch the next byte while it is on the wire.
                            if (state == STATE_READ_DATA && out_count == 3'd7) begin
                                memAddress    <= next_address(memAddress, mode);
                                memReadEnable <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= STATE_IGNORE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb/tb_spi_ram_responder.sv - scoreboard testbench for spi_ram_responder
module tb_spi_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sck = 1'b0;
    logic        csb = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        misoEnable;
    logic [16:0] memAddress;
    logic        memWriteEnable;
    logic [7:0]  memDataWrite;
    logic        memReadEnable;
    logic [7:0]  memDataRead;
    logic [1:0]  mode;

    always #5 clk = ~clk;

    spi_ram_responder #(.ADDRESS_BITS(17), .PAGE_BYTES(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .sck            (sck),
        .csb            (csb),
        .mosi           (mosi),
        .miso           (miso),
        .misoEnable     (misoEnable),
        .memAddress     (memAddress),
        .memWriteEnable (memWriteEnable),
        .memDataWrite   (memDataWrite),
        .memReadEnable  (memReadEnable),
        .memDataRead    (memDataRead),
        .mode           (mode)
    );

    logic [7:0] mem [0:131071];
    logic [7:0] mem_rdata = 8'h00;
    assign memDataRead = mem_rdata;

    always @(posedge clk) begin
        if (memWriteEnable) mem[memAddress] <= memDataWrite;
        if (memReadEnable)  mem_rdata <= mem[memAddress];
    end

    int checks = 0;
    int errors = 0;

    logic [24:0] exp_wr[$];
    logic [16:0] exp_rd[$];
    logic [7:0]  exp_miso[$];
    logic [7:0]  got_miso[$];
    logic [7:0]  tx_q[$];
    logic        watch_en = 1'b0;
    logic        saw_en = 1'b0;

    logic [24:0] mon_wr;
    logic [16:0] mon_rd;
    logic [7:0]  mon_got;
    logic [7:0]  mon_exp;

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or a byte completes.
    always @(negedge clk) begin
        if (rst) begin
            if (memWriteEnable) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write_strobe: got addr=%h data=%h, required no write", memAddress, memDataWrite);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    if ({memAddress, memDataWrite} !== mon_wr) begin
                        errors++;
                        $display("FAIL write_strobe: got addr=%h data=%h, required addr=%h data=%h",
                                 memAddress, memDataWrite, mon_wr[24:8], mon_wr[7:0]);
                    end
                end
            end
            if (memReadEnable) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL read_strobe: got addr=%h, required no read", memAddress);
                end else begin
                    mon_rd = exp_rd.pop_front();
                    if (memAddress !== mon_rd) begin
                        errors++;
                        $display("FAIL read_strobe: got addr=%h, required addr=%h", memAddress, mon_rd);
                    end
                end
            end
            if (watch_en && misoEnable) saw_en = 1'b1;
        end
        if (got_miso.size() > 0) begin
            mon_got = got_miso.pop_front();
            checks++;
            if (exp_miso.size() == 0) begin
                errors++;
                $display("FAIL miso_byte: got %h, required no byte", mon_got);
            end else begin
                mon_exp = exp_miso.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL miso_byte: got %h, required %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Mode-0 initiator: mosi set while sck low, sampled by the responder on rise,
    // miso sampled by us on rise. Bytes with index >= rx_skip go to the scoreboard.
    task automatic transfer(input int nbits, input int rx_skip, input bit keep_cs);
        logic [7:0] rx;
        logic [7:0] cur;
        int         idx;
        rx  = 8'h00;
        csb = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            idx  = i / 8;
            cur  = (idx < tx_q.size()) ? tx_q[idx] : 8'h00;
            mosi = cur[7 - (i % 8)];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            rx  = {rx[6:0], miso};
            if ((i % 8) == 7 && idx >= rx_skip) got_miso.push_back(rx);
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        if (!keep_cs) begin
            repeat (4) @(negedge clk);
            csb  = 1'b1;
            mosi = 1'b0;
            repeat (8) @(negedge clk);
        end
        tx_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'h0);
        check({tag, "_misoEnable"}, 32'(misoEnable), 32'h0);
        check({tag, "_memWriteEnable"}, 32'(memWriteEnable), 32'h0);
        check({tag, "_memReadEnable"}, 32'(memReadEnable), 32'h0);
        check({tag, "_memAddress"}, 32'(memAddress), 32'h0);
        check({tag, "_memDataWrite"}, 32'(memDataWrite), 32'h0);
        check({tag, "_mode"}, 32'(mode), 32'h1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // RDMR after reset: sequential mode, 0x40 repeated.
        tx_q = '{8'h05};
        exp_miso.push_back(8'h40); exp_miso.push_back(8'h40);
        transfer(24, 1, 1'b0);

        // WRITE 0xA5 0x5A at 0x100.
        tx_q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'hA5, 8'h5A};
        exp_wr.push_back({17'h00100, 8'hA5}); exp_wr.push_back({17'h00101, 8'h5A});
        transfer(48, 99, 1'b0);

        // READ two bytes at 0x100; the third strobe is the prefetch after the last bit 0.
        tx_q = '{8'h03, 8'h00, 8'h01, 8'h00};
        exp_rd.push_back(17'h00100); exp_rd.push_back(17'h00101); exp_rd.push_back(17'h00102);
        exp_miso.push_back(8'hA5); exp_miso.push_back(8'h5A);
        transfer(48, 4, 1'b0);

        // Byte mode: both writes land on 0x40, RDMR reads back 0x00.
        tx_q = '{8'h01, 8'h00};
        transfer(16, 99, 1'b0);
        check("mode_byte", 32'(mode), 32'h0);
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h40, 8'h11, 8'h22};
        exp_wr.push_back({17'h00040, 8'h11}); exp_wr.push_back({17'h00040, 8'h22});
        transfer(48, 99, 1'b0);
        tx_q = '{8'h05};
        exp_miso.push_back(8'h00); exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
        transfer(32, 1, 1'b0);

        // Preload 0x1F, 0x00 and 0x1FFFF in sequential mode.
        tx_q = '{8'h01, 8'h40};
        transfer(16, 99, 1'b0);
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h1F, 8'h3C};
        exp_wr.push_back({17'h0001F, 8'h3C});
        transfer(40, 99, 1'b0);
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hC3};
        exp_wr.push_back({17'h00000, 8'hC3});
        transfer(40, 99, 1'b0);
        tx_q = '{8'h02, 8'h01, 8'hFF, 8'hFF, 8'h96};
        exp_wr.push_back({17'h1FFFF, 8'h96});
        transfer(40, 99, 1'b0);

        // Page mode: 0x1F wraps to 0x00 within the 32-byte page.
        tx_q = '{8'h01, 8'h80};
        transfer(16, 99, 1'b0);
        check("mode_page", 32'(mode), 32'h2);
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h1F};
        exp_rd.push_back(17'h0001F); exp_rd.push_back(17'h00000); exp_rd.push_back(17'h00001);
        exp_miso.push_back(8'h3C); exp_miso.push_back(8'hC3);
        transfer(48, 4, 1'b0);

        // Sequential mode: 0x1FFFF wraps to 0x00000.
        tx_q = '{8'h01, 8'h40};
        transfer(16, 99, 1'b0);
        tx_q = '{8'h03, 8'h01, 8'hFF, 8'hFF};
        exp_rd.push_back(17'h1FFFF); exp_rd.push_back(17'h00000); exp_rd.push_back(17'h00001);
        exp_miso.push_back(8'h96); exp_miso.push_back(8'hC3);
        transfer(48, 4, 1'b0);

        // Partial write byte: 5 data bits then csb high, no strobe; next RDMR decodes normally.
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h50, 8'hFF};
        transfer(37, 99, 1'b0);
        tx_q = '{8'h05};
        exp_miso.push_back(8'h40);
        transfer(16, 1, 1'b0);

        // Unknown opcode 0x9F plus 32 clocks: no strobes, misoEnable stays low.
        watch_en = 1'b1;
        tx_q = '{8'h9F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        transfer(40, 99, 1'b0);
        watch_en = 1'b0;
        check("ignore_misoEnable", 32'(saw_en), 32'h0);

        // Reset in the middle of a page-mode READ data byte.
        tx_q = '{8'h01, 8'h80};
        transfer(16, 99, 1'b0);
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h1F};
        exp_rd.push_back(17'h0001F);
        transfer(36, 99, 1'b1);
        check("midread_misoEnable", 32'(misoEnable), 32'h1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midread_reset");
        csb = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        tx_q = '{8'h05};
        exp_miso.push_back(8'h40);
        transfer(16, 1, 1'b0);

        repeat (10) @(negedge clk);
        check("exp_wr_drained", 32'(exp_wr.size()), 32'h0);
        check("exp_rd_drained", 32'(exp_rd.size()), 32'h0);
        check("exp_miso_drained", 32'(exp_miso.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
